// File: rtl/edc_scrubber.sv
// edc_scrubber: background ECC scrub initiator on a Wishbone master port.
// Optional ack watchdog is enabled by defining EDC_SCRUB_TIMEOUT_EN.
module edc_scrubber #(
  parameter int          WB_DWIDTH   = 32,
  parameter int          WB_SWIDTH   = 4,
  parameter logic [31:0] BASE_ADR    = 32'h0,
  parameter int          SCRUB_WORDS = 1024,
  parameter int          INTERVAL    = 64,
  parameter int          TIMEOUT     = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_clr,
  output logic [31:0]          o_wb_adr,
  output logic [WB_SWIDTH-1:0] o_wb_sel,
  output logic                 o_wb_we,
  output logic [WB_DWIDTH-1:0] o_wb_dat,
  input  logic [WB_DWIDTH-1:0] i_wb_dat,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_err,
  input  logic                 i_edc_ce,
  output logic [15:0]          o_ce_count,
  output logic [15:0]          o_ue_count,
  output logic [31:0]          o_ue_adr,
  output logic                 o_pass_done,
  output logic                 o_irq,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int IW = (SCRUB_WORDS > 1) ? $clog2(SCRUB_WORDS) : 1;
  localparam int CW = $clog2(INTERVAL + 1);

  if (SCRUB_WORDS < 1 || INTERVAL < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("edc_scrubber: SCRUB_WORDS, INTERVAL, TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    WRITE,
    NEXT
  } state_t;

  state_t state, state_d;

  logic [IW-1:0]        idx;
  logic [CW-1:0]        cnt;
  logic                 cyc_q;
  logic                 we_q;
  logic [31:0]          adr_q;
  logic [WB_DWIDTH-1:0] dat_q;
  logic                 pass_q;
  logic [15:0]          ce_q;
  logic [15:0]          ue_q;
  logic [31:0]          ue_adr_q;
  logic                 irq_q;
  logic [31:0]          idx_adr;
  logic                 to_hit;
  logic                 ce_ev;
  logic                 ue_ev;

  assign idx_adr = BASE_ADR + (32'(idx) * 32'(WB_SWIDTH));

`ifdef EDC_SCRUB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd;
  logic          to_q;

  assign to_hit = cyc_q && !i_wb_ack && !i_wb_err
                  && (wd == WW'(TIMEOUT - 1));

  // Watchdog: counts stalled cycles of an open bus cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd   <= '0;
      to_q <= 1'b0;
    end else begin
      if (!cyc_q || i_wb_ack || i_wb_err || to_hit)
        wd <= '0;
      else
        wd <= wd + WW'(1);
      if (i_clr)
        to_q <= 1'b0;
      else if (to_hit)
        to_q <= 1'b1;
    end
  end

  assign o_timeout = to_q;
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_d;
  end

  // Next-state decode and error/correction events.
  always_comb begin
    state_d = state;
    ce_ev   = 1'b0;
    ue_ev   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_enable)
          state_d = WAIT;
      end
      WAIT: begin
        if (!i_enable)
          state_d = IDLE;
        else if (cnt == '0)
          state_d = READ;
      end
      READ: begin
        if (i_wb_err || to_hit) begin
          ue_ev   = 1'b1;
          state_d = NEXT;
        end else if (i_wb_ack) begin
          if (i_edc_ce) begin
            ce_ev   = 1'b1;
            state_d = WRITE;
          end else begin
            state_d = NEXT;
          end
        end
      end
      WRITE: begin
        if (cyc_q) begin
          if (i_wb_err || to_hit) begin
            ue_ev   = 1'b1;
            state_d = NEXT;
          end else if (i_wb_ack) begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        state_d = i_enable ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs, interval timer, word index and status counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx      <= '0;
      cnt      <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      pass_q   <= 1'b0;
      ce_q     <= '0;
      ue_q     <= '0;
      ue_adr_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      pass_q <= 1'b0;

      if (state_d == WAIT && state != WAIT)
        cnt <= CW'(INTERVAL);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - CW'(1);

      if (state != READ && state_d == READ) begin
        cyc_q <= 1'b1;
        we_q  <= 1'b0;
        adr_q <= idx_adr;
      end else if (state == READ && state_d != READ) begin
        cyc_q <= 1'b0;
      end else if (state == WRITE) begin
        // First WRITE cycle is the idle gap after the read.
        if (!cyc_q) begin
          cyc_q <= 1'b1;
          we_q  <= 1'b1;
        end else if (state_d != WRITE) begin
          cyc_q <= 1'b0;
          we_q  <= 1'b0;
        end
      end

      if (ce_ev)
        dat_q <= i_wb_dat;

      if (state == NEXT) begin
        if (idx == IW'(SCRUB_WORDS - 1)) begin
          idx    <= '0;
          pass_q <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end

      if (i_clr)
        ce_q <= '0;
      else if (ce_ev && ce_q != 16'hFFFF)
        ce_q <= ce_q + 16'd1;

      if (i_clr)
        ue_q <= '0;
      else if (ue_ev && ue_q != 16'hFFFF)
        ue_q <= ue_q + 16'd1;

      if (i_clr)
        ue_adr_q <= '0;
      else if (ue_ev)
        ue_adr_q <= adr_q;

      if (i_clr)
        irq_q <= 1'b0;
      else if (ue_ev)
        irq_q <= 1'b1;
    end
  end

  assign o_wb_adr    = adr_q;
  assign o_wb_sel    = '1;
  assign o_wb_we     = we_q;
  assign o_wb_dat    = dat_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = cyc_q;
  assign o_ce_count  = ce_q;
  assign o_ue_count  = ue_q;
  assign o_ue_adr    = ue_adr_q;
  assign o_pass_done = pass_q;
  assign o_irq       = irq_q;
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_edc_scrubber.sv
// tb_edc_scrubber: table-driven scoreboard bench for edc_scrubber.
// The watchdog sequence runs only when EDC_SCRUB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_edc_scrubber;

  localparam int SW = 4;
  localparam int IV = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic        ce;
  logic [15:0] cec;
  logic [15:0] uec;
  logic [31:0] ueadr;
  logic        pd;
  logic        irq;
  logic        busy;
  logic        tmo;

  always #5 clk = ~clk;

  edc_scrubber #(
    .WB_DWIDTH  (32),
    .WB_SWIDTH  (4),
    .BASE_ADR   (32'h0),
    .SCRUB_WORDS(SW),
    .INTERVAL   (IV),
    .TIMEOUT    (TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_enable   (en),
    .i_clr      (clr),
    .o_wb_adr   (adr),
    .o_wb_sel   (sel),
    .o_wb_we    (we),
    .o_wb_dat   (wdat),
    .i_wb_dat   (rdat),
    .o_wb_cyc   (cyc),
    .o_wb_stb   (stb),
    .i_wb_ack   (ack),
    .i_wb_err   (err),
    .i_edc_ce   (ce),
    .o_ce_count (cec),
    .o_ue_count (uec),
    .o_ue_adr   (ueadr),
    .o_pass_done(pd),
    .o_irq      (irq),
    .o_busy     (busy),
    .o_timeout  (tmo)
  );

  typedef struct {
    logic        ce;
    logic        err;
    logic [31:0] rdat;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [15:0] cec;
    logic [15:0] uec;
    int          pd;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          pd;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc_n = 0;
  int   pd_cnt = 0;
  int   t_obs = 0;

  always @(posedge clk) cyc_n++;
  always @(negedge clk) if (pd) pd_cnt++;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic ce_i, input logic err_i,
                              input logic [31:0] rd_i, input logic we_i,
                              input logic [31:0] adr_i,
                              input logic [31:0] dat_i,
                              input logic [15:0] cec_i,
                              input logic [15:0] uec_i, input int pd_i);
    vec_t v;
    v.ce   = ce_i;
    v.err  = err_i;
    v.rdat = rd_i;
    v.we   = we_i;
    v.adr  = adr_i;
    v.dat  = dat_i;
    v.cec  = cec_i;
    v.uec  = uec_i;
    v.pd   = pd_i;
    return v;
  endfunction

  task automatic wait_cyc(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cyc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL wait_cyc: no bus cycle within 200 clocks");
    end
  endtask

  // Push the expected transfer, wait for the DUT to start one, compare.
  task automatic observe(input logic we_i, input logic [31:0] adr_i,
                         input logic [31:0] dat_i, input int pd_i,
                         output bit ok);
    exp_t e;
    e.we  = we_i;
    e.adr = adr_i;
    e.dat = dat_i;
    e.pd  = pd_i;
    q.push_back(e);
    wait_cyc(ok);
    if (!ok) begin
      void'(q.pop_front());
      return;
    end
    t_obs = cyc_n;
    e = q.pop_front();
    check("stb", stb, 1);
    check("we", we, e.we);
    check("adr", adr, e.adr);
    check("sel", sel, 4'hF);
    if (e.we)
      check("wdat", wdat, e.dat);
    check("pass_done pulses", pd_cnt, e.pd);
  endtask

  task automatic xfer(input vec_t v);
    bit ok;
    observe(v.we, v.adr, v.dat, v.pd, ok);
    if (!ok) return;
    ack  = 1'b1;
    err  = v.err;
    ce   = v.ce;
    rdat = v.rdat;
    @(posedge clk);
    #1;
    ack  = 1'b0;
    err  = 1'b0;
    ce   = 1'b0;
    rdat = '0;
    @(negedge clk);
    check("ce_count", cec, v.cec);
    check("ue_count", uec, v.uec);
    check("cyc gap", cyc, 0);
  endtask

  vec_t tbl[10];
  int   t0;
  int   stray;
  int   n;
  bit   ok;

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    clr  = 1'b0;
    ack  = 1'b0;
    err  = 1'b0;
    ce   = 1'b0;
    rdat = '0;

    tbl[0] = mk(0, 0, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0);
    tbl[1] = mk(0, 0, 32'h0,        0, 32'h4, 32'h0,        0, 0, 0);
    tbl[2] = mk(0, 0, 32'h0,        0, 32'h8, 32'h0,        0, 0, 0);
    tbl[3] = mk(0, 0, 32'h0,        0, 32'hC, 32'h0,        0, 0, 0);
    tbl[4] = mk(0, 0, 32'h0,        0, 32'h0, 32'h0,        0, 0, 1);
    tbl[5] = mk(0, 0, 32'h0,        0, 32'h4, 32'h0,        0, 0, 1);
    tbl[6] = mk(1, 0, 32'hDEADBEEF, 0, 32'h8, 32'h0,        1, 0, 1);
    tbl[7] = mk(0, 0, 32'h0,        1, 32'h8, 32'hDEADBEEF, 1, 0, 1);
    tbl[8] = mk(0, 1, 32'h0,        0, 32'hC, 32'h0,        1, 1, 1);
    tbl[9] = mk(0, 0, 32'h0,        0, 32'h0, 32'h0,        1, 1, 2);

    repeat (2) @(negedge clk);
    check("rst cyc", cyc, 0);
    check("rst stb", stb, 0);
    check("rst we", we, 0);
    check("rst sel", sel, 4'hF);
    check("rst ce_count", cec, 0);
    check("rst ue_count", uec, 0);
    check("rst ue_adr", ueadr, 0);
    check("rst pass_done", pd, 0);
    check("rst irq", irq, 0);
    check("rst busy", busy, 0);
    check("rst timeout", tmo, 0);

    rst = 1'b0;
    en  = 1'b1;

    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      xfer(tbl[i]);
      if (i == 0) t0 = t_obs;
      if (i == 1) check("read spacing", t_obs - t0, IV + 3);
    end
    check("ue_adr", ueadr, 32'hC);
    check("irq sticky", irq, 1);
    check("busy", busy, 1);

    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr ce_count", cec, 0);
    check("clr ue_count", uec, 0);
    check("clr ue_adr", ueadr, 0);
    check("clr irq", irq, 0);

    xfer(mk(1, 0, 32'h12345678, 0, 32'h4, 32'h0, 1, 0, 2));
    en = 1'b0;
    xfer(mk(0, 0, 32'h0, 1, 32'h4, 32'h12345678, 1, 0, 2));
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (cyc) stray++;
    end
    check("stray cycles while disabled", stray, 0);
    check("busy after disable", busy, 0);
    en = 1'b1;
    xfer(mk(0, 0, 32'h0, 0, 32'h8, 32'h0, 1, 0, 2));

    observe(0, 32'hC, 32'h0, 2, ok);
    #1;
    rst = 1'b1;
    #1;
    check("async rst cyc", cyc, 0);
    check("async rst stb", stb, 0);
    check("async rst we", we, 0);
    check("async rst ce_count", cec, 0);
    check("async rst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    xfer(mk(0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 2));

`ifdef EDC_SCRUB_TIMEOUT_EN
    observe(0, 32'h4, 32'h0, 2, ok);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!cyc) break;
      n++;
    end
    check("timeout cyc length", n, TO);
    check("timeout flag", tmo, 1);
    check("timeout ue_count", uec, 1);
    check("timeout ue_adr", ueadr, 32'h4);
    check("timeout irq", irq, 1);
    xfer(mk(0, 0, 32'h0, 0, 32'h8, 32'h0, 0, 1, 2));
`else
    n = 0;
    check("timeout tied low", tmo, 0);
`endif

    check("scoreboard empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
